// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter that time-shares the seven-segment display among four
// requesters, holding each new owner for at least DWELL_CYCLES cycles.
module seg_display_arbiter #(
    parameter int DWELL_CYCLES = 100000000
) (
    input  logic        CLK100MHZ,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] data_in,
    output logic [3:0]  grant,
    output logic [3:0]  ack,
    output logic [7:0]  disp_val,
    output logic        disp_blank,
    output logic        busy
);
    localparam int CNT_W = $clog2(DWELL_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, HOLD, OWN} state_t;

    state_t           state_q, state_d;
    logic [1:0]       rr_last_q, rr_last_d;
    logic [1:0]       owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       grant_q, grant_d;
    logic [3:0]       ack_q, ack_d;
    logic [7:0]       disp_val_q, disp_val_d;
    logic             disp_blank_q, disp_blank_d;
    logic             busy_q, busy_d;

    logic [3:0] cand;
    logic [1:0] idx, win;
    logic       win_vld, do_grant, do_idle, owner_req;
    logic [7:0] owner_data, win_data;

    always_comb begin
        // The owner is excluded from candidates, so it can only keep the
        // display by falling through to OWN, never by a fresh re-grant.
        cand    = req & ~grant_q;
        idx     = '0;
        win     = rr_last_q;
        win_vld = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = rr_last_q + 2'(k);
            if (!win_vld && cand[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
        win_data   = data_in[{win, 3'b000} +: 8];
        owner_req  = req[owner_q];
        owner_data = data_in[{owner_q, 3'b000} +: 8];

        state_d      = state_q;
        rr_last_d    = rr_last_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        ack_d        = 4'b0000;
        disp_val_d   = disp_val_q;
        disp_blank_d = disp_blank_q;
        do_grant     = 1'b0;
        do_idle      = 1'b0;

        case (state_q)
            IDLE: do_grant = win_vld;
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (owner_req) disp_val_d = owner_data;
                end else if (win_vld) begin
                    do_grant = 1'b1;
                end else if (owner_req) begin
                    state_d    = OWN;
                    disp_val_d = owner_data;
                end else begin
                    do_idle = 1'b1;
                end
            end
            OWN: begin
                if (win_vld)        do_grant   = 1'b1;
                else if (owner_req) disp_val_d = owner_data;
                else                do_idle    = 1'b1;
            end
            default: do_idle = 1'b1;
        endcase

        if (do_grant) begin
            state_d      = HOLD;
            rr_last_d    = win;
            owner_d      = win;
            cnt_d        = CNT_W'(DWELL_CYCLES - 1);
            grant_d      = 4'b0001 << win;
            ack_d        = 4'b0001 << win;
            disp_val_d   = win_data;
            disp_blank_d = 1'b0;
        end
        if (do_idle) begin
            state_d      = IDLE;
            cnt_d        = '0;
            grant_d      = 4'b0000;
            disp_val_d   = 8'h00;
            disp_blank_d = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_last_q    <= 2'd3;
            owner_q      <= 2'd0;
            cnt_q        <= '0;
            grant_q      <= 4'b0000;
            ack_q        <= 4'b0000;
            disp_val_q   <= 8'h00;
            disp_blank_q <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_last_q    <= rr_last_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            ack_q        <= ack_d;
            disp_val_q   <= disp_val_d;
            disp_blank_q <= disp_blank_d;
            busy_q       <= busy_d;
        end
    end

    assign grant      = grant_q;
    assign ack        = ack_q;
    assign disp_val   = disp_val_q;
    assign disp_blank = disp_blank_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter with DWELL_CYCLES = 4: directed
// stimulus queues cycle-tagged expectations, a negedge monitor checks them.
module tb_seg_display_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  grant, ack;
    logic [7:0]  disp_val;
    logic        disp_blank, busy;

    seg_display_arbiter #(.DWELL_CYCLES(4)) dut (
        .CLK100MHZ(clk), .rst(rst), .req(req), .data_in(data_in),
        .grant(grant), .ack(ack), .disp_val(disp_val),
        .disp_blank(disp_blank), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] grant;
        logic [3:0] ack;
        logic [7:0] val;
        logic       blank;
        logic       busy;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expectation for the outputs visible ofs edges after the current point.
    task automatic chk(input string name, input int ofs, input logic [3:0] g,
                       input logic [3:0] a, input logic [7:0] v,
                       input logic b, input logic bz);
        exp_t e;
        e.cyc = cyc + ofs; e.name = name; e.grant = g; e.ack = a;
        e.val = v; e.blank = b; e.busy = bz;
        q.push_back(e);
    endtask

    task automatic chk_reset(input string name, input int ofs);
        chk(name, ofs, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else if (grant !== e.grant || ack !== e.ack || disp_val !== e.val ||
                         disp_blank !== e.blank || busy !== e.busy) begin
                errors++;
                $display("FAIL %s @%0d: got grant=%b ack=%b val=%h blank=%b busy=%b, want grant=%b ack=%b val=%h blank=%b busy=%b",
                         e.name, cyc, grant, ack, disp_val, disp_blank, busy,
                         e.grant, e.ack, e.val, e.blank, e.busy);
            end
        end
    end

    initial begin
        rst = 1'b1; req = 4'b0000; data_in = 32'h0;
        step(2);

        // 1: single requester, dwell, OWN tracking, release to IDLE
        chk_reset("t1_reset", 0);
        rst = 1'b0; req = 4'b0001; data_in[7:0] = 8'h5A;
        chk("t1_grant", 1, 4'b0001, 4'b0001, 8'h5A, 1'b0, 1'b1);
        chk("t1_ack_drop", 2, 4'b0001, 4'b0000, 8'h5A, 1'b0, 1'b1);
        chk("t1_own", 6, 4'b0001, 4'b0000, 8'h5A, 1'b0, 1'b1);
        step(6);
        data_in[7:0] = 8'h5B;
        chk("t1_own_track", 1, 4'b0001, 4'b0000, 8'h5B, 1'b0, 1'b1);
        step(1);
        req = 4'b0000;
        chk_reset("t1_idle", 1);
        step(2);

        // 2: all four requesting, round-robin every dwell
        rst = 1'b1; step(1); rst = 1'b0;
        chk_reset("t2_reset", 0);
        req = 4'b1111; data_in = 32'h44332211;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] oh;
            logic [7:0] v;
            oh = 4'b0001 << (k % 4);
            v  = 8'h11 * 8'((k % 4) + 1);
            chk($sformatf("t2_rr%0d", k), 4 * k + 1, oh, oh, v, 1'b0, 1'b1);
            chk($sformatf("t2_hold%0d", k), 4 * k + 4, oh, 4'b0000, v, 1'b0, 1'b1);
        end
        step(20);

        // 3: owner 2 withdraws after one cycle; value frozen, then idle
        rst = 1'b1; req = 4'b0000; step(1);
        chk_reset("t3_reset", 0);
        rst = 1'b0; req = 4'b0100; data_in = 32'h00770000;
        chk("t3_grant", 1, 4'b0100, 4'b0100, 8'h77, 1'b0, 1'b1);
        step(1);
        req = 4'b0000; data_in = 32'h00990000;
        for (int k = 1; k <= 3; k++)
            chk($sformatf("t3_frozen%0d", k), k, 4'b0100, 4'b0000, 8'h77, 1'b0, 1'b1);
        chk_reset("t3_idle", 4);
        step(5);

        // 4: owner 1 in OWN tracks data, then requester 3 preempts
        req = 4'b0010; data_in = 32'h00001000;
        chk("t4_grant", 1, 4'b0010, 4'b0010, 8'h10, 1'b0, 1'b1);
        step(5);
        chk("t4_own", 0, 4'b0010, 4'b0000, 8'h10, 1'b0, 1'b1);
        data_in = 32'h00002000;
        chk("t4_track", 1, 4'b0010, 4'b0000, 8'h20, 1'b0, 1'b1);
        step(1);
        req = 4'b1010; data_in = 32'hC3002000;
        chk("t4_preempt", 1, 4'b1000, 4'b1000, 8'hC3, 1'b0, 1'b1);
        step(2);

        // 5: competing request during HOLD waits for the full dwell
        rst = 1'b1; req = 4'b0000; step(1);
        rst = 1'b0; req = 4'b0001; data_in = 32'h00030001;
        chk("t5_grant", 1, 4'b0001, 4'b0001, 8'h01, 1'b0, 1'b1);
        step(1);
        req = 4'b0101;
        for (int k = 1; k <= 3; k++)
            chk($sformatf("t5_wait%0d", k), k, 4'b0001, 4'b0000, 8'h01, 1'b0, 1'b1);
        chk("t5_switch", 4, 4'b0100, 4'b0100, 8'h03, 1'b0, 1'b1);
        step(4);

        // 6: reset pulse mid-HOLD, then requester 0 wins first
        req = 4'b1111; rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_reset("t6_reset", 0);
        chk("t6_first", 1, 4'b0001, 4'b0001, 8'h01, 1'b0, 1'b1);
        chk("t6_ack_drop", 2, 4'b0001, 4'b0000, 8'h01, 1'b0, 1'b1);
        step(2);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations never checked, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Time-shares the single four-digit seven-segment display between up to four requesters, each of which presents an 8-bit value.
- Grants the display round-robin and guarantees each grant a minimum visible dwell time.
- Drives the 8-bit value input of the four-digit seven-segment driver, plus a blank flag used at top level to gate the anodes.

Parameters:
- DWELL_CYCLES, 100000000, minimum number of clock cycles a granted value stays on the display (1 s at 100 MHz); must be >= 1.
- CNT_W, $clog2(DWELL_CYCLES+1), width of the dwell counter; derived, not overridden.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz.
- rst  input  1  synchronous active-high reset.
- req  input  4  level request per requester; bit i = requester i.
- data_in  input  32  requester values; requester i occupies bits [8i+7:8i].
- grant  output  4  one-hot current owner; all-zero when idle.
- ack  output  4  one-cycle pulse on bit i in the first cycle requester i holds grant.
- disp_val  output  8  value fed to the display driver.
- disp_blank  output  1  1 = display must be blanked (no owner).
- busy  output  1  1 whenever state != IDLE.

Behaviour:
- Interface: one clock, CLK100MHZ; reset is synchronous and active-high, named rst. All outputs are registered.
- Reset values:
  - grant = 0, ack = 0, disp_val = 0, disp_blank = 1, busy = 0.
  - state = IDLE, rr_last = 3 (requester 0 has first priority), dwell counter = 0.
- Reset asserted mid-operation forces these values at the next edge regardless of state.
- Round-robin pick: search indices rr_last+1, rr_last+2, ... modulo 4. The first one with req high wins. rr_last updates to the winner on every grant.
- States: IDLE, HOLD (dwell counting), OWN (dwell done, owner retained).
- IDLE:
  - If any req is high at edge t, then from t+1: grant = winner, ack = winner for exactly one cycle, disp_val = winner's data_in sampled at edge t, disp_blank = 0, counter = DWELL_CYCLES-1, state = HOLD.
  - Otherwise stay in IDLE with outputs unchanged.
- HOLD:
  - The counter decrements by 1 per cycle, so HOLD lasts exactly DWELL_CYCLES cycles per grant.
  - While the owner's req is high, disp_val reloads the owner's data every cycle (1-cycle latency).
  - When the owner's req is low, disp_val freezes; the minimum dwell is honoured even if the owner withdraws.
  - Requests from other requesters are ignored until the counter reaches 0.
- HOLD with counter == 0, evaluated at that edge:
  - If any non-owner req is high: re-grant to the round-robin winner (the owner is the last candidate). Same effects as the IDLE grant: ack pulse, counter reload, remain in HOLD.
  - Else, if the owner's req is high: state = OWN, with grant and disp_val tracking unchanged.
  - Else: state = IDLE, grant = 0, disp_val = 0, disp_blank = 1.
- OWN:
  - disp_val tracks the owner's data every cycle.
  - Any non-owner req high preempts immediately: the round-robin winner is granted, with ack, reload and HOLD.
  - Owner req low with no other request: return to IDLE exactly as above.
- At most one bit of grant and of ack is ever set. ack never asserts without a new grant edge.
- A re-grant to the same requester (it is the only requester at dwell end) does not occur; that requester stays in OWN with no ack.
- busy = (state != IDLE), registered alongside state.

Test Plan (DWELL_CYCLES = 4):
1. Reset, then req = 0001 with data_in[7:0] = 0x5A -> next cycle: grant = 0001, ack = 0001 for 1 cycle, disp_val = 0x5A, disp_blank = 0, busy = 1. After 4 cycles the block enters OWN and grant holds.
2. From reset, req = 1111 held, distinct values 0x11/0x22/0x33/0x44 -> grants cycle 0,1,2,3,0 every 4 cycles, with one ack per switch and disp_val matching each owner.
3. Owner 2 granted, req[2] drops after 1 cycle, no other request -> disp_val frozen for the remaining dwell. At dwell end: grant = 0, disp_val = 0, disp_blank = 1, busy = 0.
4. Owner 1 in OWN with data changing 0x10 -> 0x20 -> disp_val follows with 1-cycle latency. Then req[3] rises -> next cycle grant = 1000, ack = 1000.
5. Owner 0 in HOLD and req[2] rises at dwell cycle 1 -> no switch until the counter reaches 0; grant = 0100 exactly DWELL_CYCLES cycles after the original grant.
6. rst pulsed for one cycle in HOLD with req = 1111 -> all outputs at reset values next cycle. After release, the first grant goes to requester 0.
